// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - RV32M divide constants and divider state encoding
package div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] FUNC3_DIV  = 3'b100;
    localparam logic [2:0] FUNC3_DIVU = 3'b101;
    localparam logic [2:0] FUNC3_REM  = 3'b110;
    localparam logic [2:0] FUNC3_REMU = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [XLEN-1:0] XLEN_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_unit
    import div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic              is_rem_q, is_rem_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    // One restoring step: the dividend sits in quot_q and shifts out MSB first
    // while quotient bits shift in at the bottom.
    logic [XLEN:0]     shifted, diff, rem_step;
    logic              qbit;
    logic [XLEN-1:0]   quot_step, q_fin, r_fin;

    always_comb begin
        shifted   = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
        diff      = shifted - {1'b0, dvsr_q};
        qbit      = ~diff[XLEN];
        rem_step  = qbit ? diff : shifted;
        quot_step = {quot_q[XLEN-2:0], qbit};
        q_fin     = q_neg_q ? -quot_step : quot_step;
        r_fin     = r_neg_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
    end

    logic            is_signed, want_rem, a_neg, b_neg, overflow;
    logic [XLEN-1:0] abs_a, abs_b;

    always_comb begin
        is_signed = ~func3[0];
        want_rem  = func3[1];
        a_neg     = is_signed & op_a[XLEN-1];
        b_neg     = is_signed & op_b[XLEN-1];
        abs_a     = a_neg ? -op_a : op_a;
        abs_b     = b_neg ? -op_b : op_b;
        overflow  = is_signed && (op_a == XLEN_MIN_NEG) && (op_b == '1);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvsr_d   = dvsr_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DIVIDE: begin
                    rem_d  = rem_step;
                    quot_d = quot_step;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        result_d = is_rem_q ? r_fin : q_fin;
                        state_d  = DONE;
                        cnt_d    = '0;
                    end
                end
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start) begin
                        if (op_b == '0) begin
                            result_d = want_rem ? op_a : '1;
                            state_d  = DONE;
                        end else if (overflow) begin
                            result_d = want_rem ? '0 : XLEN_MIN_NEG;
                            state_d  = DONE;
                        end else begin
                            state_d  = DIVIDE;
                            cnt_d    = '0;
                            rem_d    = '0;
                            quot_d   = abs_a;
                            dvsr_d   = abs_b;
                            is_rem_d = want_rem;
                            q_neg_d  = a_neg ^ b_neg;
                            r_neg_d  = a_neg;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == DIVIDE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;
    import div_unit_pkg::*;

    logic            clk;
    logic            rst;
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int total;
    int bad;

    div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or on timeout).
    // k counts cycles after the accept edge; hold keeps start high until done.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input bit hold, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_busy);
        int k;
        int busy_cnt;
        start = 1'b1;
        func3 = f3;
        op_a  = a;
        op_b  = b;
        k = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            k++;
            if (!hold) begin
                start = 1'b0;
                op_a  = 32'hDEAD_BEEF;
                op_b  = 32'h0BAD_F00D;
            end
            if (busy) busy_cnt++;
        end while (!done && k < 40);
        start = 1'b0;
        check({tag, " latency"}, k, exp_lat);
        check({tag, " busy cycles"}, busy_cnt, exp_busy);
        check({tag, " result"}, result, exp_res);
    endtask

    initial begin
        logic [31:0] prev;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        func3 = FUNC3_DIVU;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu 100/7", FUNC3_DIVU, 32'd100, 32'd7, 1'b0, 32'd14, 33, 32);
        @(negedge clk);
        check("done one cycle", {31'd0, done}, 32'd0);
        run_op("remu 100/7", FUNC3_REMU, 32'd100, 32'd7, 1'b0, 32'd2, 33, 32);
        @(negedge clk);
        run_op("div -100/7", FUNC3_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, 32'hFFFF_FFF2, 33, 32);
        @(negedge clk);
        run_op("rem -100/7", FUNC3_REM, 32'hFFFF_FF9C, 32'd7, 1'b0, 32'hFFFF_FFFE, 33, 32);
        @(negedge clk);
        run_op("div 100/-7", FUNC3_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF2, 33, 32);
        @(negedge clk);
        run_op("rem 100/-7", FUNC3_REM, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'd2, 33, 32);
        @(negedge clk);
        run_op("divu max/16", FUNC3_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 33, 32);
        @(negedge clk);
        run_op("remu max/16", FUNC3_REMU, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'hF, 33, 32);
        @(negedge clk);
        run_op("div by zero", FUNC3_DIV, 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 1, 0);
        @(negedge clk);
        check("dz done one cycle", {31'd0, done}, 32'd0);
        run_op("rem by zero", FUNC3_REM, 32'h1234, 32'd0, 1'b0, 32'h1234, 1, 0);
        @(negedge clk);
        run_op("div overflow", FUNC3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1, 0);
        @(negedge clk);
        run_op("rem overflow", FUNC3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 1, 0);
        @(negedge clk);
        run_op("divu 0x80000000/-1", FUNC3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 33, 32);
        @(negedge clk);

        // Flush during iteration 10: no done, result untouched.
        prev = result;
        start = 1'b1;
        func3 = FUNC3_DIVU;
        op_a  = 32'd1000;
        op_b  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-flush busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        start = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        check("flush result", result, prev);
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("flush quiet", seen, 0);
        end

        run_op("divu held start", FUNC3_DIVU, 32'd1000, 32'd3, 1'b1, 32'd333, 33, 32);
        @(negedge clk);
        run_op("remu held start", FUNC3_REMU, 32'd1000, 32'd3, 1'b1, 32'd1, 33, 32);
        @(negedge clk);

        // Asynchronous reset mid-divide.
        start = 1'b1;
        func3 = FUNC3_DIVU;
        op_a  = 32'd100;
        op_b  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst done", {31'd0, done}, 32'd0);
        check("async rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: second start issued in the done cycle of the first.
        run_op("b2b first", FUNC3_DIVU, 32'd100, 32'd7, 1'b0, 32'd14, 33, 32);
        run_op("b2b second", FUNC3_REMU, 32'd100, 32'd7, 1'b0, 32'd2, 33, 32);
        @(negedge clk);
        check("b2b idle done", {31'd0, done}, 32'd0);
        check("b2b idle busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider implementing the RV32M DIV, DIVU, REM and REMU instructions. It sits beside the execute stage. It accepts operands already forwarded by the execute stage and returns a result that the execute stage steers into the EX/MEM pipeline. While the divider is busy, the hazard unit holds `pc_en`, holds the IF/ID enable and bubbles ID/EX.

## Interface
- XLEN, 32, operand and result width.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock domain, asynchronous assert, active-high.
- start  input  1  request a division; sampled only when the unit can accept.
- func3  input  3  operation select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  dividend.
- op_b  input  XLEN  divisor.
- flush  input  1  kill any in-flight operation (branch or jump taken).
- busy  output  1  high while iterating; the execute stage stalls on it.
- done  output  1  one-cycle pulse; `result` is valid in this cycle.
- result  output  XLEN  quotient or remainder; held until the next accepted start.

## Operation
- States are IDLE, DIVIDE and DONE.
- **Acceptance:** start is accepted when state is IDLE or DONE. A start arriving in DIVIDE is ignored.
- **Captured on accept:** func3 class (signed flag, remainder flag), |op_a| and |op_b| (magnitude only for signed ops), quotient sign (a_sign ^ b_sign) and remainder sign (a_sign). Inputs need not be held after the accept edge.
- **Special cases** resolve at the accept edge and go straight to DONE:
  - Divisor = 0: quotient = all ones; remainder = op_a.
  - Signed overflow (op_a = 0x8000_0000, op_b = 0xFFFF_FFFF, DIV/REM): quotient = 0x8000_0000; remainder = 0.
- **Normal path:** restoring division.
  - 33-bit partial remainder; one quotient bit per cycle, MSB first.
  - 5-bit iteration counter runs 0..31.
  - At count 31 the final iteration completes. On the same edge the sign correction is applied (two's-complement negate where the captured sign is 1), the selected quotient or remainder is registered into `result`, and state goes to DONE.
- **DONE** lasts exactly one cycle, then IDLE unless a new start is accepted.
- **flush:** synchronous. Any state goes to IDLE. done is forced 0 and the counter cleared; `result` keeps its old value. flush beats start in the same cycle.
- **Reset:** state IDLE, busy 0, done 0, result 0, counter 0, internal registers 0.

## Timing
- busy = (state == DIVIDE). done = (state == DONE). Both are registered-state decodes with no combinational path from inputs.
- Normal latency: start sampled at edge N, then busy is high for cycles N+1 .. N+32.
- DONE follows edge N+32, so done is high in the cycle after edge N+32. The result appears 33 cycles after start.
- Special-case latency: done is high in the cycle after edge N (1 cycle); busy never rises.
- Back-to-back: a start during DONE is accepted. The next operation's busy rises on the following cycle with no idle gap.
- Reset asserted mid-DIVIDE: all outputs return to reset values immediately, independent of clk.

## Structure
- Shared core package holds:
  - func3 constants FUNC3_DIV, FUNC3_DIVU, FUNC3_REM, FUNC3_REMU;
  - the M-extension funct7 constant 0000001;
  - the state encoding (2-bit enum: IDLE, DIVIDE, DONE).
- Single module, no sub-module. The iteration step (shift, trial subtract, select) is a small combinational block inside it.
- Hazard-unit and execute-stage integration is not part of this block.

## Test plan
- DIVU: op_a = 100, op_b = 7, start for 1 cycle -> busy for 32 cycles, then done pulse with result 14. The REMU repeat gives 2.
- DIV: op_a = -100 (0xFFFF_FF9C), op_b = 7 -> result 0xFFFF_FFF2 (-14). REM gives 0xFFFF_FFFE (-2), matching the dividend sign.
- Divide by zero, DIV, op_a = 0x1234 -> done one cycle after start with result 0xFFFF_FFFF, busy never high. REM gives 0x1234.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000 in 1 cycle. REM -> 0.
- flush at iteration 10 of a DIVU -> IDLE next cycle, no done pulse, result unchanged. A new start then completes normally, and a start held high during DIVIDE does not restart the operation.
- rst asserted mid-DIVIDE -> busy, done and result read 0 before the next clk edge. The back-to-back case is covered by a start in the done cycle: its done pulse follows 33 cycles later.
